// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: instruction memory,
// hazard unit stall controls, branch redirect, and the exported IF/ID fields.
interface fetch_stage_if #(
    parameter int ADDR_W = 16
);
    logic              pc_write;
    logic              if_id_write;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic [15:0]       if_id_instr;
    logic [ADDR_W-1:0] if_id_pc_plus1;
    logic              if_id_valid;
    logic [3:0]        if_id_opcode;
    logic [3:0]        if_id_rs;
    logic [3:0]        if_id_rt;
    logic              halted;
    logic [15:0]       fetch_count;

    modport master (
        input  pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid,
               if_id_opcode, if_id_rs, if_id_rt, halted, fetch_count
    );

    modport slave (
        output pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid,
               if_id_opcode, if_id_rs, if_id_rt, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, IF/ID pipeline register, branch flush and
// a two-state RUN/HALTED machine entered when a HALT word is latched.
module fetch_stage #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       instr_reg, instr_next;
    logic [ADDR_W-1:0] pc_plus1_reg, pc_plus1_next;
    logic              valid_reg, valid_next;
    logic [0:0]        state_reg, state_next;
    logic [15:0]       count_reg, count_next;

    logic [ADDR_W-1:0] pc_inc;
    logic              fetch_is_halt;

    assign pc_inc        = pc_reg + ADDR_W'(1);
    assign fetch_is_halt = (bus.imem_rdata[15:12] == OP_HALT);

    always_comb begin
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        pc_plus1_next = pc_plus1_reg;
        valid_next    = valid_reg;
        state_next    = state_reg;
        count_next    = count_reg;

        if (bus.branch_taken) begin
            // Redirect overrides stalls and halt; whatever sits in IF/ID is wrong-path.
            pc_next    = bus.branch_target;
            instr_next = 16'h0000;
            valid_next = 1'b0;
            state_next = RUN;
        end else if (state_reg == RUN) begin
            if (bus.pc_write && !(bus.if_id_write && fetch_is_halt))
                pc_next = pc_inc;
            if (bus.if_id_write) begin
                instr_next    = bus.imem_rdata;
                pc_plus1_next = pc_inc;
                valid_next    = 1'b1;
                if (count_reg != 16'hFFFF)
                    count_next = count_reg + 16'd1;
                if (fetch_is_halt)
                    state_next = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= 16'h0000;
            pc_plus1_reg <= '0;
            valid_reg    <= 1'b0;
            state_reg    <= RUN;
            count_reg    <= 16'h0000;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            pc_plus1_reg <= pc_plus1_next;
            valid_reg    <= valid_next;
            state_reg    <= state_next;
            count_reg    <= count_next;
        end
    end

    assign bus.imem_addr      = pc_reg;
    assign bus.if_id_instr    = instr_reg;
    assign bus.if_id_pc_plus1 = pc_plus1_reg;
    assign bus.if_id_valid    = valid_reg;
    assign bus.if_id_opcode   = instr_reg[15:12];
    assign bus.if_id_rs       = instr_reg[7:4];
    assign bus.if_id_rt       = instr_reg[3:0];
    assign bus.halted         = (state_reg == HALTED);
    assign bus.fetch_count    = count_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver steps a behavioural model and queues
// the expected post-edge state; a monitor pops and compares on the falling edge.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_w = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    fetch_stage_if #(.ADDR_W(16)) bus_m ();
    fetch_stage_if #(.ADDR_W(16)) bus_w ();

    assign bus_m.imem_rdata = mem[bus_m.imem_addr];
    assign bus_w.imem_rdata = mem[bus_w.imem_addr];

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0010)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    // Second instance only exercises the PC wrap from 0xFFFF.
    fetch_stage #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_w),
        .bus   (bus_w)
    );

    assign bus_w.pc_write      = 1'b1;
    assign bus_w.if_id_write   = 1'b1;
    assign bus_w.branch_taken  = 1'b0;
    assign bus_w.branch_target = 16'h0000;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ppc;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state: the architectural view after each edge.
    logic [15:0] m_pc, m_instr, m_ppc, m_cnt;
    logic        m_valid, m_halted;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_step(input logic r, input logic pw, input logic iw,
                              input logic bt, input logic [15:0] tgt);
        logic [15:0] word;
        logic        is_halt;
        if (!r) begin
            m_pc = 16'h0010; m_instr = 16'h0; m_ppc = 16'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
        end else if (bt) begin
            m_pc = tgt; m_instr = 16'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (!m_halted) begin
            word    = mem[m_pc];
            is_halt = (word[15:12] == 4'hF);
            if (iw) begin
                m_instr = word;
                m_ppc   = m_pc + 16'd1;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (is_halt) m_halted = 1'b1;
            end
            if (pw && !(iw && is_halt)) m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw,
                         input logic bt, input logic [15:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n               = r;
        bus_m.pc_write      = pw;
        bus_m.if_id_write   = iw;
        bus_m.branch_taken  = bt;
        bus_m.branch_target = tgt;
        model_step(r, pw, iw, bt, tgt);
        e.stamp = cyc + 1;
        e.pc = m_pc; e.instr = m_instr; e.ppc = m_ppc;
        e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].stamp == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("imem_addr",   int'(bus_m.imem_addr),      int'(e.pc));
            chk("if_id_instr", int'(bus_m.if_id_instr),    int'(e.instr));
            chk("pc_plus1",    int'(bus_m.if_id_pc_plus1), int'(e.ppc));
            chk("if_id_valid", int'(bus_m.if_id_valid),    int'(e.valid));
            chk("opcode",      int'(bus_m.if_id_opcode),   int'(e.instr[15:12]));
            chk("rs",          int'(bus_m.if_id_rs),       int'(e.instr[7:4]));
            chk("rt",          int'(bus_m.if_id_rt),       int'(e.instr[3:0]));
            chk("halted",      int'(bus_m.halted),         int'(e.halted));
            chk("fetch_count", int'(bus_m.fetch_count),    int'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        bus_m.pc_write = 1'b0; bus_m.if_id_write = 1'b0;
        bus_m.branch_taken = 1'b0; bus_m.branch_target = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h1123; mem[16'h0001] = 16'h2234;
        mem[16'h0002] = 16'h3345; mem[16'h0003] = 16'h4456;
        mem[16'h0004] = 16'h5567; mem[16'h0005] = 16'hF000;
        mem[16'h0010] = 16'h7A5C; mem[16'hFFFF] = 16'h1ABC;

        // Wrap: PC 0xFFFF fetches with pc_plus1 0x0000 and then addresses 0x0000.
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_reset_addr", int'(bus_w.imem_addr), 16'hFFFF);
        chk("wrap_reset_valid", int'(bus_w.if_id_valid), 0);
        rst_w = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_instr", int'(bus_w.if_id_instr), 16'h1ABC);
        chk("wrap_pc_plus1", int'(bus_w.if_id_pc_plus1), 16'h0000);
        chk("wrap_next_addr", int'(bus_w.imem_addr), 16'h0000);

        // Reset for two cycles, then release and fetch from 0x0010.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        // Branch flush while stalled.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        // Stream with one stall at PC=2, then run into HALT at 5.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

        // Randomised traffic: stalls, independent writes, branches, rare resets.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) != 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0),
                  16'($urandom_range(0, 255)));
        end

        // Saturation: HALT-free memory, 65535+ consecutive fetches.
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            mem[i] = w;
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        mem[m_pc] = 16'hF123;
        repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 4-bit-opcode pipeline. Holds the PC, drives the instruction-memory address, and latches the fetched word into IF/ID. The IF/ID fields it exports (opcode, rs, rt) are the inputs the hazard detection unit inspects; the unit's pc_write/if_id_write outputs come back here to stall fetch. Also handles branch redirect/flush and the halt (opcode 4'b1111) state.

## Interface
- ADDR_W, 16, PC / instruction-memory address width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous, active-low reset
- pc_write  input  1  1 = PC may advance; 0 = hold PC
- if_id_write  input  1  1 = IF/ID may load; 0 = hold IF/ID
- branch_taken  input  1  resolved taken branch/jump from a later stage
- branch_target  input  ADDR_W  redirect address, valid with branch_taken
- imem_addr  output  ADDR_W  instruction-memory address, equal to PC register
- imem_rdata  input  16  instruction word, combinational read of imem_addr
- if_id_instr  output  16  latched instruction
- if_id_pc_plus1  output  ADDR_W  address of latched instruction + 1
- if_id_valid  output  1  IF/ID holds a real instruction
- if_id_opcode  output  4  if_id_instr[15:12]
- if_id_rs  output  4  if_id_instr[7:4]
- if_id_rt  output  4  if_id_instr[3:0]
- halted  output  1  fetch is in HALTED state
- fetch_count  output  16  number of valid instructions latched into IF/ID, saturating

## Operation
- Instruction format fixed: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt. Opcode 4'b1111 = HALT.
- State machine, two states: RUN, HALTED.
- Priority each cycle: rst_n low > branch_taken > HALTED hold > stall/advance.
- Reset (rst_n=0 at edge): PC=RESET_PC, if_id_instr=16'h0000, if_id_pc_plus1=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN. Reset mid-halt or mid-stall returns to RUN.
- branch_taken=1 (any state, ignores pc_write/if_id_write): PC<=branch_target; IF/ID flushed (instr=0, valid=0, pc_plus1 unchanged); state<=RUN; fetch_count not incremented. A HALT in IF/ID at that time is wrong-path and is discarded.
- RUN, no branch:
  - pc_write=1: PC<=PC+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000), unless the fetched word is HALT (below).
  - pc_write=0: PC holds.
  - if_id_write=1: if_id_instr<=imem_rdata, if_id_pc_plus1<=PC+1 (wrapped), valid<=1, fetch_count+1 saturating at 16'hFFFF.
  - if_id_write=0: IF/ID holds all fields including valid.
  - If imem_rdata[15:12]==4'b1111 and if_id_write=1: latch it as normal, PC holds regardless of pc_write, state<=HALTED.
  - pc_write and if_id_write are honoured independently.
- HALTED, no branch: PC, IF/ID, fetch_count held; halted=1. Exits only via branch_taken or reset.
- halted is a registered output equal to (state==HALTED).

## Timing
- Fetch latency 1 cycle: word at PC==A in cycle n appears on if_id_instr in cycle n+1, pc_plus1=A+1.
- Branch: branch_taken in cycle n -> imem_addr=branch_target in n+1; if_id_valid=0 in n+1; target instruction in IF/ID in n+2.
- Stall: each cycle with pc_write=if_id_write=0 adds exactly one cycle; no instruction lost or duplicated.
- All outputs registered except imem_addr (PC register) and IF/ID field slices; no combinational path from any input to any output.
- HALT latched at edge n -> halted=1 from cycle n+1.

## Test plan
- Reset: rst_n=0 for 2 cycles with RESET_PC=16'h0010 -> imem_addr=0x0010, if_id_valid=0, if_id_instr=0, halted=0, fetch_count=0; release -> if_id_instr=mem[0x10], pc_plus1=0x0011 next cycle.
- Stream + stall: mem[0..3]=0x1123,0x2234,0x3345,0x4456, stall one cycle at PC=2 -> IF/ID sequence 0x1123,0x2234,0x2234,0x3345,0x4456; fetch_count=4.
- Branch flush: branch_taken=1, branch_target=0x0040 while pc_write=0 -> next cycle imem_addr=0x0040, if_id_valid=0, instr=0; fetch_count unchanged.
- Halt: mem[5]=0xF000 -> IF/ID=0xF000, halted=1, imem_addr stays 5 for 10 cycles with pc_write=1; then branch_taken to 0x0000 -> halted=0, RUN resumes.
- Wrap: RESET_PC=16'hFFFF -> fetch 0xFFFF with pc_plus1=0x0000, next imem_addr=0x0000.
- Reset mid-halt and fetch_count preloaded to 0xFFFF by 65535 fetches -> stays 0xFFFF on further fetches; rst_n=0 clears all to reset values.
